// File: rtl/npu_vec_core.sv
// npu_vec_core: LANES-wide signed multiply-accumulate with bias, shift, saturation and an output FIFO.
// Optional ReLU clamp is compiled in when the macro NPU_RELU_EN is defined.

module npu_vec_core #(
  parameter int LANES      = 4,
  parameter int DW         = 8,
  parameter int ACC_W      = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT      = 0
) (
  input  logic                CLKEXT,
  input  logic                RST_GLO,
  input  logic                START,
  input  logic [7:0]          LEN,
  input  logic [DW-1:0]       BIAS_IN,
  input  logic                RELU_MODE,
  input  logic [LANES*DW-1:0] D_IN,
  input  logic [LANES*DW-1:0] W_IN,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic                OUT_READY,
  output logic                OUT_VALID,
  output logic [DW-1:0]       D_OUT,
  output logic                FIFO_FULL,
  output logic                FIFO_EMPTY,
  output logic                BUSY,
  output logic                DONE
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2**(DW-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2**(DW-1)));

  typedef enum logic [1:0] {IDLE, ACC, BIAS, WRITE} state_t;

  state_t                  state;
  logic [7:0]              len_q;
  logic [7:0]              beat_cnt;
  logic signed [DW-1:0]    bias_q;
  logic                    relu_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [DW-1:0]    res_q;
  logic                    done_q;

  logic signed [2*DW-1:0]  prod [LANES];
  logic signed [ACC_W-1:0] beat_sum;
  logic signed [ACC_W:0]   biased;
  logic signed [ACC_W:0]   shifted;
  logic signed [DW-1:0]    sat_val;
  logic signed [DW-1:0]    result;

  logic [DW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count;
  logic                    push;
  logic                    pop;

  // Per-lane signed products, summed into the accumulator width (wraps with acc).
  always_comb begin
    // NOTE: every combinational variable gets a value before any branch so no latch is inferred.
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i]  = $signed(D_IN[i*DW +: DW]) * $signed(W_IN[i*DW +: DW]);
      beat_sum = beat_sum + ACC_W'(prod[i]);
    end
  end

  // One guard bit keeps acc + bias from wrapping before the clamp.
  always_comb begin
    biased  = $signed({acc[ACC_W-1], acc}) + (ACC_W+1)'(bias_q);
    shifted = biased >>> SHIFT;
    if (shifted > SAT_MAX)      sat_val = {1'b0, {(DW-1){1'b1}}};
    else if (shifted < SAT_MIN) sat_val = {1'b1, {(DW-1){1'b0}}};
    else                        sat_val = shifted[DW-1:0];
    result = sat_val;
`ifdef NPU_RELU_EN
    if (relu_q && sat_val[DW-1]) result = '0;
`endif
  end

`ifndef NPU_RELU_EN
  logic unused_relu;
  assign unused_relu = relu_q;
`endif

  assign push = (state == WRITE) && !FIFO_FULL;
  assign pop  = OUT_VALID && OUT_READY;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      state    <= IDLE;
      len_q    <= '0;
      beat_cnt <= '0;
      bias_q   <= '0;
      relu_q   <= 1'b0;
      acc      <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            len_q    <= LEN;
            bias_q   <= BIAS_IN;
            relu_q   <= RELU_MODE;
            acc      <= '0;
            beat_cnt <= '0;
            state    <= (LEN != 8'd0) ? ACC : BIAS;
          end
        end
        ACC: begin
          if (IN_VALID) begin
            acc      <= acc + beat_sum;
            beat_cnt <= beat_cnt + 8'd1;
            if (beat_cnt + 8'd1 == len_q) state <= BIAS;
          end
        end
        BIAS: begin
          res_q <= result;
          state <= WRITE;
        end
        WRITE: begin
          // Holds here while the FIFO is full; the result is never dropped.
          if (!FIFO_FULL) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; D_OUT is forced to zero while the FIFO is empty instead.
  always_ff @(posedge CLKEXT) begin
    if (push) mem[wr_ptr] <= res_q;
  end

  assign FIFO_EMPTY = (count == '0);
  assign FIFO_FULL  = (count == DEPTH_C);
  assign OUT_VALID  = !FIFO_EMPTY;
  assign D_OUT      = FIFO_EMPTY ? '0 : mem[rd_ptr];
  assign IN_READY   = (state == ACC);
  assign BUSY       = (state != IDLE);
  assign DONE       = done_q;

endmodule
